// File: rtl/product_accumulator.sv
// Sums NUM_TERMS unsigned 16-bit products per group.
// A one-cycle o_valid pulse carries each completed group sum.
module product_accumulator #(
  parameter logic [3:0] INSTANCE_ID = 4'b1,
  parameter int         NUM_TERMS   = 8,
  parameter int         ACC_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [15:0]      Z,
  input  logic             clear,
  output logic             o_valid,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(NUM_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  generate
    if (NUM_TERMS < 2 || NUM_TERMS > 256 ||
        ACC_W < 16 + $clog2(NUM_TERMS)) begin : g_bad_cfg
      $error("product_accumulator %0d: bad NUM_TERMS/ACC_W",
             INSTANCE_ID);
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] z_ext;
  logic [ACC_W-1:0] sum;

  assign z_ext = ACC_W'(Z);
  assign sum   = acc + z_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      // clear wins over a same-cycle term, even a final one
      if (clear) begin
        state  <= IDLE;
        acc    <= '0;
        count  <= '0;
        o_busy <= 1'b0;
      end else if (i_valid) begin
        unique case (state)
          IDLE: begin
            acc    <= z_ext;
            count  <= ONE;
            state  <= ACCUM;
            o_busy <= 1'b1;
          end
          ACCUM: begin
            if (count == LAST) begin
              o_sum   <= sum;
              o_valid <= 1'b1;
              acc     <= '0;
              count   <= '0;
              state   <= IDLE;
              o_busy  <= 1'b0;
            end else begin
              acc   <= sum;
              count <= count + ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator.
// Driver queues expected sums; a monitor checks each o_valid pulse.
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [15:0] Z;
  logic        clear;
  logic        o_valid;
  logic [23:0] o_sum;
  logic        o_busy;

  int total;
  int bad;
  int cyc;

  int exp_q[$];
  int cyc_q[$];

  product_accumulator #(
    .INSTANCE_ID(4'b1),
    .NUM_TERMS  (8),
    .ACC_W      (24)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .Z      (Z),
    .clear  (clear),
    .o_valid(o_valid),
    .o_sum  (o_sum),
    .o_busy (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] z, input logic clr);
    @(negedge clk);
    i_valid = 1'b1;
    Z       = z;
    clear   = clr;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic expect_sum(input int s);
    exp_q.push_back(s);
    cyc_q.push_back(cyc);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: every pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'(o_sum), 32'hFFFF_FFFF);
      end else begin
        check("group_sum", 32'(o_sum), 32'(exp_q.pop_front()));
        check("pulse_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    i_valid = 1'b0;
    Z       = 16'hxxxx;
    clear   = 1'bx;
    #23;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_sum", 32'(o_sum), 0);
    check("rst_busy", 32'(o_busy), 0);
    Z     = 16'h0;
    clear = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    check("idle_busy", 32'(o_busy), 0);

    // eight max products
    for (int i = 0; i < 8; i++) send(16'd65025, 1'b0);
    expect_sum(520200);
    idle(3);
    check("sum_hold", 32'(o_sum), 32'h07F008);

    // 1..8 with gaps, tracking busy
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 1'b0);
      if (i < 8) begin
        check("busy_mid", 32'(o_busy), 1);
        idle(int'($urandom_range(0, 3)));
        check("busy_gap", 32'(o_busy), 1);
      end else begin
        expect_sum(36);
        check("busy_done", 32'(o_busy), 0);
      end
    end
    idle(2);

    // back-to-back groups
    for (int i = 0; i < 8; i++) send(16'd225, 1'b0);
    expect_sum(1800);
    for (int i = 0; i < 8; i++) send(16'd510, 1'b0);
    expect_sum(4080);
    idle(3);

    // abort a partial group
    for (int i = 0; i < 3; i++) send(16'd100, 1'b0);
    do_clear();
    check("clr_busy", 32'(o_busy), 0);
    check("clr_sum", 32'(o_sum), 4080);
    for (int i = 0; i < 8; i++) send(16'd1, 1'b0);
    expect_sum(8);
    idle(2);

    // clear coincident with final term
    for (int i = 0; i < 7; i++) send(16'd3, 1'b0);
    send(16'd3, 1'b1);
    check("clr8_busy", 32'(o_busy), 0);
    idle(2);
    check("clr8_sum", 32'(o_sum), 8);
    for (int i = 0; i < 8; i++) send(16'd2, 1'b0);
    expect_sum(16);
    idle(2);

    // clear while idle has no effect
    do_clear();
    check("idle_clr_busy", 32'(o_busy), 0);
    check("idle_clr_sum", 32'(o_sum), 16);

    // asynchronous reset mid-group
    for (int i = 0; i < 5; i++) send(16'd7, 1'b0);
    check("pre_rst_busy", 32'(o_busy), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 0);
    check("arst_sum", 32'(o_sum), 0);
    check("arst_busy", 32'(o_busy), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) send(16'd1, 1'b0);
    expect_sum(8);
    idle(4);

    check("drain", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
